rope_shock_monitor: RTL and testbench



---
 rtl/rope_shock_monitor.sv | 173 +++++++++++++++++
 tb/tb_rope_shock_monitor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rope_shock_monitor.sv
// rope_shock_monitor
// Turns player/rope contact into gameplay consequences (stun, life loss,
// post-hit grace blinking, game over). All decisions are taken once per frame
// on startOfFrame; every output is registered.
// Optional feature macro: ROPE_SHOCK_BLINK_EN -- when defined, flashOn blinks
// during GRACE; when undefined, flashOn stays high in GRACE and the blink
// counter is not built.
module rope_shock_monitor #(
  parameter int ROPES        = 6,
  parameter int STUN_FRAMES  = 60,
  parameter int GRACE_FRAMES = 90,
  parameter int LIVES        = 3,
  parameter int BLINK_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  logic [ROPES-1:0][1:0] electroStatus,
  input  logic [ROPES-1:0]      ropeTouch,
  input  logic                  restart,
  output logic                  playerFrozen,
  output logic                  flashOn,
  output logic                  shockHit,
  output logic                  lifeLost,
  output logic [2:0]            livesLeft,
  output logic                  gameOver
);

  localparam int MAX_FRAMES = (STUN_FRAMES > GRACE_FRAMES) ? STUN_FRAMES : GRACE_FRAMES;
  localparam int TW = $clog2(MAX_FRAMES + 1);
  localparam logic [TW-1:0] STUN_LOAD  = TW'(STUN_FRAMES);
  localparam logic [TW-1:0] GRACE_LOAD = TW'(GRACE_FRAMES);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [2:0]    LIVES_LOAD = 3'(LIVES);

  // Parameter sanity: lives must fit the 3-bit counter and be non-zero,
  // and every timed interval must be at least one frame long.
  if (LIVES < 1 || LIVES > 7 || STUN_FRAMES < 1 || GRACE_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_config
    $error("rope_shock_monitor: illegal parameter combination");
  end

  typedef enum logic [1:0] {ALIVE, STUNNED, GRACE, DEAD} state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    lives_reg;
  logic          touch_e_reg;
  logic          touch_he_reg;
  logic          frozen_reg;
  logic          flash_reg;
  logic          shock_reg;
  logic          lost_reg;
  logic          over_reg;

`ifdef ROPE_SHOCK_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic GRACE_FLASH = 1'b0;
  logic [BW-1:0] blink_reg;
`else
  localparam logic GRACE_FLASH = 1'b1;
`endif

  // Per-rope contact classification; status 11 matches neither class.
  logic [ROPES-1:0] hit_e;
  logic [ROPES-1:0] hit_he;
  for (genvar gi = 0; gi < ROPES; gi++) begin : g_rope
    assign hit_e[gi]  = ropeTouch[gi] && (electroStatus[gi] == 2'b01);
    assign hit_he[gi] = ropeTouch[gi] && (electroStatus[gi] == 2'b10);
  end

  logic now_e, now_he, seen_e, seen_he;
  logic [2:0] lives_dec;
  assign now_e     = |hit_e;
  assign now_he    = |hit_he;
  // A touch in the SOF cycle itself still counts for that frame's decision.
  assign seen_e    = touch_e_reg | now_e;
  assign seen_he   = touch_he_reg | now_he;
  assign lives_dec = (lives_reg == 3'd0) ? 3'd0 : lives_reg - 3'd1;

  // Frame-rate state machine with sticky touch flags and registered outputs.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_reg    <= ALIVE;
      timer_reg    <= '0;
      lives_reg    <= LIVES_LOAD;
      touch_e_reg  <= 1'b0;
      touch_he_reg <= 1'b0;
      frozen_reg   <= 1'b0;
      flash_reg    <= 1'b1;
      shock_reg    <= 1'b0;
      lost_reg     <= 1'b0;
      over_reg     <= 1'b0;
`ifdef ROPE_SHOCK_BLINK_EN
      blink_reg    <= '0;
`endif
    end else begin
      shock_reg <= 1'b0;
      lost_reg  <= 1'b0;
      if (startOfFrame) begin
        touch_e_reg  <= 1'b0;
        touch_he_reg <= 1'b0;
        case (state_reg)
          ALIVE, STUNNED: begin
            if (seen_he) begin
              // High-electro beats plain electro and interrupts a stun.
              lost_reg   <= 1'b1;
              lives_reg  <= lives_dec;
              frozen_reg <= 1'b0;
              if (lives_dec == 3'd0) begin
                state_reg <= DEAD;
                over_reg  <= 1'b1;
                flash_reg <= 1'b0;
                timer_reg <= '0;
              end else begin
                state_reg <= GRACE;
                flash_reg <= GRACE_FLASH;
                timer_reg <= GRACE_LOAD;
`ifdef ROPE_SHOCK_BLINK_EN
                blink_reg <= '0;
`endif
              end
            end else if (state_reg == ALIVE) begin
              if (seen_e) begin
                shock_reg  <= 1'b1;
                state_reg  <= STUNNED;
                frozen_reg <= 1'b1;
                timer_reg  <= STUN_LOAD;
              end
            end else if (timer_reg == TIMER_ONE) begin
              state_reg  <= ALIVE;
              frozen_reg <= 1'b0;
              timer_reg  <= '0;
            end else begin
              timer_reg <= timer_reg - TIMER_ONE;
            end
          end
          GRACE: begin
            if (timer_reg == TIMER_ONE) begin
              state_reg <= ALIVE;
              flash_reg <= 1'b1;
              timer_reg <= '0;
            end else begin
              timer_reg <= timer_reg - TIMER_ONE;
`ifdef ROPE_SHOCK_BLINK_EN
              if (blink_reg == BLINK_LAST) begin
                flash_reg <= ~flash_reg;
                blink_reg <= '0;
              end else begin
                blink_reg <= blink_reg + 1'b1;
              end
`endif
            end
          end
          default: begin
            // DEAD: hold until restart.
          end
        endcase
      end else begin
        touch_e_reg  <= touch_e_reg | now_e;
        touch_he_reg <= touch_he_reg | now_he;
      end
    end
  end

  assign playerFrozen = frozen_reg;
  assign flashOn      = flash_reg;
  assign shockHit     = shock_reg;
  assign lifeLost     = lost_reg;
  assign livesLeft    = lives_reg;
  assign gameOver     = over_reg;

endmodule

// File: tb/tb_rope_shock_monitor.sv
// Self-checking bench for rope_shock_monitor: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// frame-number based behavioural model.
module tb_rope_shock_monitor;

  localparam int ROPES        = 6;
  localparam int STUN_FRAMES  = 60;
  localparam int GRACE_FRAMES = 90;
  localparam int LIVES        = 3;
  localparam int BLINK_FRAMES = 4;
`ifdef ROPE_SHOCK_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  startOfFrame;
  logic [ROPES-1:0][1:0] electroStatus;
  logic [ROPES-1:0]      ropeTouch;
  logic                  restart;
  logic                  playerFrozen, flashOn, shockHit, lifeLost, gameOver;
  logic [2:0]            livesLeft;

  rope_shock_monitor #(
    .ROPES(ROPES), .STUN_FRAMES(STUN_FRAMES), .GRACE_FRAMES(GRACE_FRAMES),
    .LIVES(LIVES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .electroStatus(electroStatus), .ropeTouch(ropeTouch), .restart(restart),
    .playerFrozen(playerFrozen), .flashOn(flashOn), .shockHit(shockHit),
    .lifeLost(lifeLost), .livesLeft(livesLeft), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_shock  = 0;
  int n_lost   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame-number based) ----------------
  localparam int M_ALIVE = 0, M_STUN = 1, M_GRACE = 2, M_DEAD = 3;
  bit m_valid = 1'b0;
  int m_mode, m_lives, m_end, m_gstart, sof_n;
  bit m_e, m_he, now_e, now_he, se, she;

  always @(posedge clk) begin
    now_e = 1'b0;
    now_he = 1'b0;
    for (int i = 0; i < ROPES; i++) begin
      if (ropeTouch[i] && electroStatus[i] == 2'b01) now_e = 1'b1;
      if (ropeTouch[i] && electroStatus[i] == 2'b10) now_he = 1'b1;
    end
    if (reset || restart) begin
      if (reset) m_valid = 1'b1;
      m_mode = M_ALIVE; m_lives = LIVES; m_e = 1'b0; m_he = 1'b0;
    end else if (startOfFrame) begin
      sof_n++;
      se = m_e | now_e;
      she = m_he | now_he;
      m_e = 1'b0; m_he = 1'b0;
      if ((m_mode == M_ALIVE || m_mode == M_STUN) && she) begin
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) m_mode = M_DEAD;
        else begin m_mode = M_GRACE; m_end = sof_n + GRACE_FRAMES; m_gstart = sof_n; end
      end else if (m_mode == M_ALIVE && se) begin
        m_mode = M_STUN; m_end = sof_n + STUN_FRAMES;
      end else if ((m_mode == M_STUN || m_mode == M_GRACE) && sof_n == m_end) begin
        m_mode = M_ALIVE;
      end
    end else begin
      m_e = m_e | now_e;
      m_he = m_he | now_he;
    end
  end

  // Pulses are derived from the model's decision: they appear exactly in the
  // cycle after an SOF that started a stun or took a life.
  bit m_shock, m_lost;
  int prev_mode, prev_lives;
  always @(posedge clk) begin
    #0;
  end

  function automatic int exp_flash_at(input int k);
    if (!BLINK) return 1;
    return (k / BLINK_FRAMES) % 2;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  int last_lives = LIVES;
  int last_mode = M_ALIVE;
  int last_sof = 0;
  always @(negedge clk) begin
    if (shockHit) n_shock++;
    if (lifeLost) n_lost++;
    if (m_valid) begin
      chk("frozen", playerFrozen, int'(m_mode == M_STUN));
      chk("gameOver", gameOver, int'(m_mode == M_DEAD));
      chk("livesLeft", livesLeft, m_lives);
      chk("flashOn", flashOn,
          (m_mode == M_DEAD) ? 0 : (m_mode == M_GRACE) ? exp_flash_at(sof_n - m_gstart) : 1);
      // A stun pulse: model moved into STUN on the latest edge.
      chk("shockHit", shockHit,
          int'(m_mode == M_STUN && last_mode == M_ALIVE && sof_n != last_sof));
      chk("lifeLost", lifeLost, int'(m_lives < last_lives && sof_n != last_sof));
    end
    last_lives = m_lives;
    last_mode = m_mode;
    last_sof = sof_n;
  end

  // ---------------- stimulus helpers ----------------
  int snap_shock, snap_lost, snap_frozen, snap_flash;

  task automatic cyc(input logic sof, input logic [ROPES-1:0] touch,
                     input logic [ROPES-1:0][1:0] st, input logic rst_in, input logic rs_in);
    @(negedge clk);
    startOfFrame = sof; ropeTouch = touch; electroStatus = st;
    reset = rst_in; restart = rs_in;
  endtask

  // One frame: SOF cycle (with optional touch), then three idle cycles.
  // Outputs right after the first idle cycle reflect that SOF's decision.
  task automatic do_frame(input logic [ROPES-1:0] touch, input logic [ROPES-1:0][1:0] st);
    cyc(1'b1, touch, st, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    snap_shock = shockHit; snap_lost = lifeLost;
    snap_frozen = playerFrozen; snap_flash = flashOn;
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [ROPES-1:0][1:0] st_one(input int rope, input logic [1:0] v);
    logic [ROPES-1:0][1:0] s;
    s = '0;
    s[rope] = v;
    return s;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_lives"}, livesLeft, 3);
    chk({tag, "_flash"}, flashOn, 1);
    chk({tag, "_frozen"}, playerFrozen, 0);
    chk({tag, "_shock"}, shockHit, 0);
    chk({tag, "_lost"}, lifeLost, 0);
    chk({tag, "_over"}, gameOver, 0);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) do_frame('0, '0);
  endtask

  logic [ROPES-1:0][1:0] st_tmp;
  logic [ROPES-1:0][1:0] st_all11;

  initial begin
    int base_s, base_l, frozen_cnt;
    reset = 1'b1; restart = 1'b0; startOfFrame = 1'b0; ropeTouch = '0; electroStatus = '0;
    sof_n = 0; m_end = 0; m_gstart = 0; m_mode = M_ALIVE; m_lives = LIVES;
    st_all11 = {ROPES{2'b11}};

    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check_reset_values("reset");
    $display("step reset: lives=%0d flash=%0d", livesLeft, flashOn);

    // Stun: touch rope 2 (E) for one cycle, then SOF.
    base_s = n_shock;
    cyc(1'b0, 6'b000100, st_one(2, 2'b01), 1'b0, 1'b0);
    do_frame('0, '0);
    chk("stun_shock", snap_shock, 1);
    chk("stun_frozen", snap_frozen, 1);
    frozen_cnt = snap_frozen;
    for (int i = 0; i < 69; i++) begin
      do_frame('0, '0);
      frozen_cnt += snap_frozen;
    end
    chk("stun_frames", frozen_cnt, 60);
    chk("stun_pulses", n_shock - base_s, 1);
    chk("stun_lives", livesLeft, 3);
    $display("step stun: frozen_frames=%0d", frozen_cnt);

    // Life loss: rope 0 HE, then grace with random touches on every SOF.
    base_l = n_lost; base_s = n_shock;
    cyc(1'b0, 6'b000001, st_one(0, 2'b10), 1'b0, 1'b0);
    do_frame('0, '0);
    chk("loss_pulse", snap_lost, 1);
    chk("loss_lives", livesLeft, 2);
    chk("grace_flash_0", snap_flash, BLINK ? 0 : 1);
    for (int k = 1; k < GRACE_FRAMES; k++) begin
      st_tmp = 12'($urandom);
      do_frame(6'b111111, st_tmp);
      chk("grace_flash", snap_flash, exp_flash_at(k));
    end
    do_frame('0, '0);
    chk("grace_end_flash", snap_flash, 1);
    chk("grace_lost_pulses", n_lost - base_l, 1);
    chk("grace_shock_pulses", n_shock - base_s, 0);
    $display("step life loss: lives=%0d", livesLeft);

    // Game over: restart, then three HE hits separated by full grace.
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("go_restart_lives", livesLeft, 3);
    for (int h = 1; h <= 3; h++) begin
      do_frame(6'b000001, st_one(0, 2'b10));
      chk("go_lives", livesLeft, 3 - h);
      chk("go_over", gameOver, int'(h == 3));
      if (h < 3) idle_frames(GRACE_FRAMES);
    end
    chk("go_flash", flashOn, 0);
    base_l = n_lost;
    do_frame(6'b000001, st_one(0, 2'b10));
    chk("dead_lives", livesLeft, 0);
    chk("dead_no_pulse", n_lost - base_l, 0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("restart_lives", livesLeft, 3);
    chk("restart_over", gameOver, 0);
    $display("step game over: restarted lives=%0d", livesLeft);

    // Priority: rope 1 E and rope 4 HE in the same frame.
    st_tmp = '0; st_tmp[1] = 2'b01; st_tmp[4] = 2'b10;
    cyc(1'b0, 6'b010010, st_tmp, 1'b0, 1'b0);
    do_frame('0, '0);
    chk("prio_lost", snap_lost, 1);
    chk("prio_shock", snap_shock, 0);
    chk("prio_lives", livesLeft, 2);
    idle_frames(GRACE_FRAMES);
    // Touch coincident with SOF counts; HE at stun frame 10 ends the stun.
    do_frame(6'b000100, st_one(2, 2'b01));
    chk("sof_touch_shock", snap_shock, 1);
    chk("sof_touch_frozen", snap_frozen, 1);
    idle_frames(9);
    chk("stun_f9_frozen", playerFrozen, 1);
    do_frame(6'b010000, st_one(4, 2'b10));
    chk("stun_he_lost", snap_lost, 1);
    chk("stun_he_frozen", snap_frozen, 0);
    chk("stun_he_lives", livesLeft, 1);
    idle_frames(GRACE_FRAMES);
    $display("step priority: lives=%0d", livesLeft);

    // Reset mid-STUNNED.
    do_frame(6'b001000, st_one(3, 2'b01));
    chk("pre_reset_frozen", snap_frozen, 1);
    idle_frames(3);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check_reset_values("mid_stun_reset");

    // Status 11 is idle, both before and during SOF.
    cyc(1'b0, 6'b111111, st_all11, 1'b0, 1'b0);
    do_frame(6'b111111, st_all11);
    chk("st11_shock", snap_shock, 0);
    chk("st11_lost", snap_lost, 0);
    chk("st11_frozen", snap_frozen, 0);

    // Restart coincident with an HE SOF.
    cyc(1'b1, 6'b000001, st_one(0, 2'b10), 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("restart_he_lives", livesLeft, 3);
    chk("restart_he_lost", lifeLost, 0);
    $display("step boundaries: lives=%0d", livesLeft);

    // Randomized run, checked every cycle by the model.
    for (int n = 0; n < 6000; n++) begin
      logic [ROPES-1:0] t;
      t = '0;
      if ($urandom_range(0, 9) == 0) t[$urandom_range(0, ROPES - 1)] = 1'b1;
      st_tmp = 12'($urandom);
      cyc(($urandom_range(0, 3) == 0), t, st_tmp,
          ($urandom_range(0, 1499) == 0), ($urandom_range(0, 399) == 0));
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    $display("step random: sof_count=%0d", sof_n);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
